// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM stage between EX and WB of the 5-stage in-order pipeline.
// Waits for the data-memory data_ok pulse on issued requests, and holds a
// response in a buffer if WB is not ready for it. Extracts byte/half/word
// load data with sign or zero extension. A flush kills the stage and drops
// the response that is still outstanding for the killed instruction.
// Exports a forwarding bus with a data_ready flag for load-use stalls in ID.
// Optional build macro MS_ALE_EN adds the ms_ale output, which flags
// misaligned loads.
`timescale 1ns/1ps

module mem_stage_hs #(
  parameter int XLEN   = 32,
  parameter int PC_W   = 32,
  parameter int DEST_W = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           es_to_ms_valid,
  output logic                           ms_allow_in,
  input  logic [PC_W+XLEN+DEST_W+5:0]    es_ms_bus,
  input  logic                           ws_allow_in,
  output logic                           ms_to_ws_valid,
  output logic [PC_W+DEST_W+XLEN:0]      ms_ws_bus,
  output logic [DEST_W+XLEN+1:0]         ms_fwd_bus,
  input  logic                           data_sram_data_ok,
  input  logic [XLEN-1:0]                data_sram_rdata,
  input  logic                           flush
`ifdef MS_ALE_EN
  ,
  output logic                           ms_ale
`endif
);

  localparam int OFF_W = (XLEN == 64) ? 3 : 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              gr_we;
    logic [DEST_W-1:0] dest;
    logic [XLEN-1:0]   alu_result;
    logic              res_from_mem;
    logic [2:0]        ld_op;
    logic              req_issued;
  } es_ms_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              gr_we;
    logic [DEST_W-1:0] dest;
    logic [XLEN-1:0]   alu_result;
    logic              res_from_mem;
    logic [2:0]        ld_op;
  } ms_payload_t;

  es_ms_t          es_in;
  ms_payload_t     ms_r;
  state_t          state, state_nxt;
  logic            ms_valid;
  logic            cancel_pending, cancel_nxt;
  logic [XLEN-1:0] buffer;
  logic            data_ok_mine, ready_go, capture, leave, hold_load;
  logic [OFF_W-1:0] byte_off, half_off, word_off;
  logic [XLEN-1:0] raw, lane_b, lane_h, lane_w, load_data, final_result;

  assign es_in = es_ms_bus;

  // A data_ok that belongs to a flushed instruction is never ours.
  assign data_ok_mine = data_sram_data_ok && !cancel_pending;

  // Ready-to-go: only a waiting memory access can hold the stage.
  always_comb begin
    case (state)
      S_WAIT:  ready_go = data_ok_mine;
      default: ready_go = 1'b1;
    endcase
  end

  assign ms_allow_in    = !ms_valid || (ready_go && ws_allow_in);
  assign ms_to_ws_valid = ms_valid && ready_go && !flush;
  assign capture        = es_to_ms_valid && ms_allow_in;
  assign leave          = ms_valid && ready_go && ws_allow_in;
  assign hold_load      = ms_valid && (state == S_WAIT) && data_ok_mine && !ws_allow_in;

  // Next-state and cancel bookkeeping for the outstanding-response tracker.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt  = state;
    cancel_nxt = (cancel_pending && !data_sram_data_ok) ||
                 (flush && ms_valid && (state == S_WAIT) && !data_ok_mine);
    if (flush)
      state_nxt = S_IDLE;
    else if (capture)
      state_nxt = es_in.req_issued ? S_WAIT : S_IDLE;
    else if (hold_load)
      state_nxt = S_HOLD;
    else if (leave || !ms_valid)
      state_nxt = S_IDLE;
  end

  // Control state: valid bit, FSM, cancel flag and response buffer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      ms_valid       <= 1'b0;
      state          <= S_IDLE;
      cancel_pending <= 1'b0;
      buffer         <= '0;
    end else begin
      state          <= state_nxt;
      cancel_pending <= cancel_nxt;
      if (flush)
        ms_valid <= 1'b0;
      else if (ms_allow_in)
        ms_valid <= es_to_ms_valid;
      if (hold_load)
        buffer <= data_sram_rdata;
    end
  end

  // Instruction payload captured from EX.
  always_ff @(posedge clk) begin
    // NOTE: the payload has no reset; every consumer qualifies it with ms_valid.
    if (capture) begin
      ms_r.pc           <= es_in.pc;
      ms_r.gr_we        <= es_in.gr_we;
      ms_r.dest         <= es_in.dest;
      ms_r.alu_result   <= es_in.alu_result;
      ms_r.res_from_mem <= es_in.res_from_mem;
      ms_r.ld_op        <= es_in.ld_op;
    end
  end

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    raw         = (state == S_HOLD) ? buffer : data_sram_rdata;
    byte_off    = ms_r.alu_result[OFF_W-1:0];
    half_off    = byte_off;
    half_off[0] = 1'b0;
    word_off    = byte_off;
    word_off[1:0] = 2'b00;
    lane_b      = raw >> {byte_off, 3'b000};
    lane_h      = raw >> {half_off, 3'b000};
    lane_w      = raw >> {word_off, 3'b000};
    load_data   = raw;
    case (ms_r.ld_op)
      3'b001: begin load_data = {XLEN{lane_b[7]}};  load_data[7:0]  = lane_b[7:0];  end
      3'b010: begin load_data = '0;                 load_data[7:0]  = lane_b[7:0];  end
      3'b011: begin load_data = {XLEN{lane_h[15]}}; load_data[15:0] = lane_h[15:0]; end
      3'b100: begin load_data = '0;                 load_data[15:0] = lane_h[15:0]; end
      3'b101: if (XLEN == 64) begin
                load_data = {XLEN{lane_w[31]}}; load_data[31:0] = lane_w[31:0];
              end
      3'b110: if (XLEN == 64) begin
                load_data = '0;                 load_data[31:0] = lane_w[31:0];
              end
      default: load_data = raw;
    endcase
  end

`ifdef MS_ALE_EN
  logic misaligned;

  // Misaligned-load detection on the natural alignment of each access size.
  always_comb begin
    misaligned = 1'b0;
    if (ms_r.res_from_mem) begin
      case (ms_r.ld_op)
        3'b011, 3'b100: misaligned = byte_off[0];
        3'b000:         misaligned = (XLEN == 64) ? (byte_off != '0) : (byte_off[1:0] != 2'b00);
        3'b101, 3'b110: misaligned = (XLEN == 64) && (byte_off[1:0] != 2'b00);
        default:        misaligned = 1'b0;
      endcase
    end
  end

  assign ms_ale = ms_to_ws_valid && misaligned;
`endif

  // Result select: loads return extracted data, everything else the ALU value.
  always_comb begin
    final_result = ms_r.res_from_mem ? load_data : ms_r.alu_result;
`ifdef MS_ALE_EN
    if (misaligned)
      final_result = ms_r.alu_result;
`endif
  end

  assign ms_ws_bus  = {ms_r.pc, ms_r.gr_we, ms_r.dest, final_result};
  assign ms_fwd_bus = {ms_valid && ms_r.gr_we,
                       ms_valid && !((state == S_WAIT) && ms_r.res_from_mem && !data_ok_mine),
                       ms_r.dest, final_result};

endmodule

// File: tb/tb_mem_stage_hs.sv
// Testbench for mem_stage_hs: directed stimulus, expected retirements pushed
// to a scoreboard queue and popped by an independent monitor on every WB
// transfer. Handshake, forwarding and hold behaviour are checked in-line.
`timescale 1ns/1ps

module tb_mem_stage_hs;

  localparam int XLEN = 32;
  localparam int PC_W = 32;
  localparam int DEST_W = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allow_in;
  logic [74:0] es_ms_bus;
  logic        ws_allow_in;
  logic        ms_to_ws_valid;
  logic [69:0] ms_ws_bus;
  logic [38:0] ms_fwd_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        flush;
`ifdef MS_ALE_EN
  logic        ms_ale;
`endif

  int n_compared = 0;
  int n_mismatched = 0;
  logic [69:0] sb[$];

  mem_stage_hs #(.XLEN(XLEN), .PC_W(PC_W), .DEST_W(DEST_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allow_in       (ms_allow_in),
    .es_ms_bus         (es_ms_bus),
    .ws_allow_in       (ws_allow_in),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_ws_bus         (ms_ws_bus),
    .ms_fwd_bus        (ms_fwd_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .flush             (flush)
`ifdef MS_ALE_EN
    ,
    .ms_ale            (ms_ale)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_compared++;
    if (act !== exp_v) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic logic [74:0] mk_in(input logic [31:0] pc, input logic gr_we,
                                        input logic [4:0] dest, input logic [31:0] alu,
                                        input logic rfm, input logic [2:0] ld_op,
                                        input logic req);
    return {pc, gr_we, dest, alu, rfm, ld_op, req};
  endfunction

  function automatic logic [69:0] mk_ws(input logic [31:0] pc, input logic gr_we,
                                        input logic [4:0] dest, input logic [31:0] res);
    return {pc, gr_we, dest, res};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and wait (bounded) until it is captured.
  task automatic send(input logic [74:0] bus, input logic retire, input logic [69:0] exp_bus);
    es_ms_bus = bus;
    es_to_ms_valid = 1'b1;
    if (retire) sb.push_back(exp_bus);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ms_allow_in) break;
    end
    check("send_accept", ms_allow_in, 1'b1);
    tick();
  endtask

  // Issue a memory instruction whose response arrives the next cycle.
  task automatic load1(input logic [74:0] bus, input logic [69:0] exp_bus, input logic [31:0] rdata);
    send(bus, 1'b1, exp_bus);
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = rdata;
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'hDEAD_BEEF;
  endtask

  // Scoreboard monitor: every WB transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allow_in) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL unexpected_retire: got %0h expected none", ms_ws_bus);
      end else begin
        check("retire_bus", ms_ws_bus, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_ms_bus = '0;
    ws_allow_in = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    flush = 1'b0;
    tick();
    tick();

    // Reset state
    @(negedge clk);
    check("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    check("rst_allow_in", ms_allow_in, 1'b1);
    check("rst_we_valid", ms_fwd_bus[38], 1'b0);
    check("rst_data_ready", ms_fwd_bus[37], 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // LW with data_ok on the third cycle after entry
    send(mk_in(32'h100, 1, 5'd5, 32'h1000, 1, 3'b000, 1), 1, mk_ws(32'h100, 1, 5'd5, 32'h8000_00F0));
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("lw_w1_data_ready", ms_fwd_bus[37], 1'b0);
    check("lw_w1_valid", ms_to_ws_valid, 1'b0);
    check("lw_w1_allow_in", ms_allow_in, 1'b0);
    check("lw_w1_we_valid", ms_fwd_bus[38], 1'b1);
    tick();
    @(negedge clk);
    check("lw_w2_data_ready", ms_fwd_bus[37], 1'b0);
    check("lw_w2_valid", ms_to_ws_valid, 1'b0);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h8000_00F0;
    @(negedge clk);
    check("lw_ok_valid", ms_to_ws_valid, 1'b1);
    check("lw_ok_data_ready", ms_fwd_bus[37], 1'b1);
    check("lw_ok_fwd_result", ms_fwd_bus[31:0], 32'h8000_00F0);
    tick();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    check("lw_after_valid", ms_to_ws_valid, 1'b0);
    tick();

    // Lane extraction
    load1(mk_in(32'h110, 1, 5'd6, 32'h2001, 1, 3'b001, 1), mk_ws(32'h110, 1, 5'd6, 32'hFFFF_FF80), 32'h0000_8000);
    load1(mk_in(32'h114, 1, 5'd6, 32'h2002, 1, 3'b100, 1), mk_ws(32'h114, 1, 5'd6, 32'h0000_BEEF), 32'hBEEF_0000);
    load1(mk_in(32'h118, 1, 5'd6, 32'h2002, 1, 3'b011, 1), mk_ws(32'h118, 1, 5'd6, 32'hFFFF_BEEF), 32'hBEEF_0000);
    load1(mk_in(32'h11C, 1, 5'd6, 32'h2003, 1, 3'b010, 1), mk_ws(32'h11C, 1, 5'd6, 32'h0000_00A5), 32'hA500_0000);
    load1(mk_in(32'h120, 1, 5'd6, 32'h2000, 1, 3'b001, 1), mk_ws(32'h120, 1, 5'd6, 32'h0000_007F), 32'h0000_007F);
    load1(mk_in(32'h124, 1, 5'd6, 32'h2004, 1, 3'b000, 1), mk_ws(32'h124, 1, 5'd6, 32'hCAFE_BABE), 32'hCAFE_BABE);
    load1(mk_in(32'h128, 1, 5'd6, 32'h2001, 1, 3'b111, 1), mk_ws(32'h128, 1, 5'd6, 32'h0102_0304), 32'h0102_0304);

    // Store waits for data_ok and returns the ALU value
    send(mk_in(32'h1C0, 0, 5'd0, 32'h2100, 0, 3'b000, 1), 1, mk_ws(32'h1C0, 0, 5'd0, 32'h2100));
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("st_wait_valid", ms_to_ws_valid, 1'b0);
    check("st_wait_data_ready", ms_fwd_bus[37], 1'b1);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hFFFF_FFFF;
    tick();
    data_sram_data_ok = 1'b0;

    // Response arrives while WB is stalled: buffered and held
    send(mk_in(32'h140, 1, 5'd7, 32'h3000, 1, 3'b000, 1), 1, mk_ws(32'h140, 1, 5'd7, 32'h1234_5678));
    es_to_ms_valid = 1'b0;
    ws_allow_in = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234_5678;
    @(negedge clk);
    check("hold_ok_valid", ms_to_ws_valid, 1'b1);
    check("hold_ok_allow_in", ms_allow_in, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_valid", ms_to_ws_valid, 1'b1);
      check("hold_allow_in", ms_allow_in, 1'b0);
      check("hold_result", ms_ws_bus[31:0], 32'h1234_5678);
      tick();
    end
    ws_allow_in = 1'b1;
    @(negedge clk);
    check("hold_release_allow_in", ms_allow_in, 1'b1);
    tick();
    @(negedge clk);
    check("hold_after_valid", ms_to_ws_valid, 1'b0);
    tick();

    // Flush in WAIT; the stale response must be swallowed
    send(mk_in(32'h180, 1, 5'd8, 32'h3F00, 1, 3'b000, 1), 0, '0);
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush_valid", ms_to_ws_valid, 1'b0);
    tick();
    flush = 1'b0;
    send(mk_in(32'h184, 1, 5'd9, 32'h4000, 1, 3'b000, 1), 1, mk_ws(32'h184, 1, 5'd9, 32'h5555_5555));
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    check("cancel_swallow_valid", ms_to_ws_valid, 1'b0);
    check("cancel_swallow_data_ready", ms_fwd_bus[37], 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    check("cancel_wait_valid", ms_to_ws_valid, 1'b0);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h5555_5555;
    @(negedge clk);
    check("cancel_second_valid", ms_to_ws_valid, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;

    // Flush in the same cycle as a capture: flush wins
    es_ms_bus = mk_in(32'h1A0, 1, 5'd3, 32'h77, 0, 3'b000, 0);
    es_to_ms_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("flush_cap_valid", ms_to_ws_valid, 1'b0);
    check("flush_cap_we_valid", ms_fwd_bus[38], 1'b0);
    check("flush_cap_allow_in", ms_allow_in, 1'b1);
    tick();

    // Back-to-back: load then two ALU ops, one retirement per cycle
    send(mk_in(32'h200, 1, 5'd10, 32'h5000, 1, 3'b000, 1), 1, mk_ws(32'h200, 1, 5'd10, 32'h1111_1111));
    es_ms_bus = mk_in(32'h204, 1, 5'd11, 32'hCAFE_0001, 0, 3'b000, 0);
    sb.push_back(mk_ws(32'h204, 1, 5'd11, 32'hCAFE_0001));
    @(negedge clk);
    check("b2b_wait_allow_in", ms_allow_in, 1'b0);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111_1111;
    @(negedge clk);
    check("b2b_ld_valid", ms_to_ws_valid, 1'b1);
    check("b2b_ld_allow_in", ms_allow_in, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;
    es_ms_bus = mk_in(32'h208, 1, 5'd12, 32'h0000_BEEF, 0, 3'b000, 0);
    sb.push_back(mk_ws(32'h208, 1, 5'd12, 32'h0000_BEEF));
    @(negedge clk);
    check("b2b_alu1_valid", ms_to_ws_valid, 1'b1);
    tick();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("b2b_alu2_valid", ms_to_ws_valid, 1'b1);
    tick();
    @(negedge clk);
    check("b2b_idle_valid", ms_to_ws_valid, 1'b0);
    tick();

    // Misaligned word load
`ifdef MS_ALE_EN
    send(mk_in(32'h240, 1, 5'd12, 32'h1002, 1, 3'b000, 1), 1, mk_ws(32'h240, 1, 5'd12, 32'h1002));
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h89AB_CDEF;
    @(negedge clk);
    check("ale_set", ms_ale, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;
    send(mk_in(32'h244, 1, 5'd12, 32'h1004, 1, 3'b000, 1), 1, mk_ws(32'h244, 1, 5'd12, 32'h89AB_CDEF));
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h89AB_CDEF;
    @(negedge clk);
    check("ale_clear", ms_ale, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
`else
    load1(mk_in(32'h240, 1, 5'd12, 32'h1002, 1, 3'b000, 1), mk_ws(32'h240, 1, 5'd12, 32'h89AB_CDEF), 32'h89AB_CDEF);
`endif

    // Reset while waiting: state and cancel tracking are dropped
    send(mk_in(32'h260, 1, 5'd13, 32'h6000, 1, 3'b000, 1), 0, '0);
    es_to_ms_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_wait_valid", ms_to_ws_valid, 1'b0);
    check("rst_wait_allow_in", ms_allow_in, 1'b1);
    check("rst_wait_we_valid", ms_fwd_bus[38], 1'b0);
    tick();
    load1(mk_in(32'h264, 1, 5'd13, 32'h6004, 1, 3'b000, 1), mk_ws(32'h264, 1, 5'd13, 32'h0BAD_F00D), 32'h0BAD_F00D);

    tick();
    tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Parametrised successor MEM stage for the 5-stage in-order pipeline, between EX and WB.
- Replaces fixed single-cycle load return with a data_ok handshake, so the stage stalls until load data returns.
- Extracts byte/halfword load data with sign/zero extension.
- Supports pipeline flush, including discard of an in-flight load response.
- Exports a forwarding bus with a data-ready flag so ID can stall on load-use.

Parameters:
- XLEN, 32, data/address width (32 or 64)
- PC_W, 32, PC width
- DEST_W, 5, register index width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- es_to_ms_valid  in  1  EX holds valid instruction
- ms_allow_in  out  1  MEM can accept
- es_ms_bus  in  PC_W+XLEN+DEST_W+6  {pc, gr_we, dest, alu_result, res_from_mem, ld_op[2:0], req_issued}, MSB first
- ws_allow_in  in  1  WB can accept
- ms_to_ws_valid  out  1  MEM result valid to WB
- ms_ws_bus  out  PC_W+1+DEST_W+XLEN  {pc, gr_we, dest, final_result}
- ms_fwd_bus  out  2+DEST_W+XLEN  {we_valid, data_ready, dest, final_result}
- data_sram_data_ok  in  1  load/store response pulse, one per issued request
- data_sram_rdata  in  XLEN  response data, valid with data_ok
- flush  in  1  kill MEM contents (exception/branch redirect)

Interface rule (already decided): reset is synchronous, active-high; clock is clk.

Behaviour:
- Reset values: ms_valid=0, state=IDLE, cancel_pending=0, buffer=0. All outputs are driven from these:
  - ms_to_ws_valid=0, ms_allow_in=1.
  - ms_fwd_bus we_valid=0, data_ready=0.
- Latch rule: capture es_ms_bus when es_to_ms_valid && ms_allow_in.
- Handshake:
  - ms_allow_in = !ms_valid || (ready_go && ws_allow_in).
  - ms_to_ws_valid = ms_valid && ready_go && !flush.
- State machine:
  - IDLE: no outstanding response. On entry, req_issued=1 goes to WAIT; otherwise ready_go=1.
  - WAIT: ready_go = data_sram_data_ok (combinational bypass of rdata).
    - data_ok && ws_allow_in: leave in the same cycle.
    - data_ok && !ws_allow_in: store rdata in buffer, go to HOLD.
  - HOLD: ready_go=1, result taken from buffer. Return to IDLE, or to WAIT if the next entry has req_issued.
- Stores (req_issued=1, res_from_mem=0) also wait for data_ok; final_result=alu_result.
- Load extraction uses alu_result[1:0] (and [2] for XLEN=64) to select the lane.
  - ld_op: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned.
  - For XLEN=64: 101 word signed, 110 word unsigned, 000 dword.
  - Other codes are treated as full width.
- Back-to-back entry: a new instruction may enter in the same cycle the old one leaves. ms_ws_bus reflects the old instruction that cycle.
- flush:
  - Next cycle ms_valid=0.
  - If flushed in WAIT, set cancel_pending=1; the next data_ok is swallowed, then cancel_pending clears.
  - While cancel_pending=1, a newly entered req_issued instruction must not take that data_ok. It waits for the following one.
  - flush in the same cycle as a capture wins: ms_valid=0.
- Forwarding:
  - we_valid = ms_valid && gr_we.
  - data_ready = 0 while in WAIT with res_from_mem and no data_ok this cycle; otherwise 1.
- Reset mid-WAIT: the state is dropped and cancel_pending is cleared. The memory side is reset together with the stage.

Optional Feature:
- Macro: MS_ALE_EN.
- When defined: adds output ms_ale (1 bit).
  - Asserted with ms_to_ws_valid for a misaligned load: half with addr[0]=1, word with addr[1:0]!=0.
  - final_result is then forced to alu_result (the bad address).
- When undefined: no port, misalignment is ignored, and lane extraction uses the truncated address.

Test Plan:
- LW, req_issued=1, data_ok 3 cycles after entry with rdata=0x8000_00F0 -> ms_to_ws_valid exactly in the data_ok cycle, final_result=0x8000_00F0, data_ready=0 for 2 cycles.
- LB signed at addr 0x...1, rdata=0x0000_8000 -> result 0xFFFF_FF80. LHU at addr 0x...2, rdata=0xBEEF_0000 -> 0x0000_BEEF.
- Load data_ok while ws_allow_in=0 for 4 cycles, rdata=0x1234_5678 -> state HOLD, result stays 0x1234_5678, ms_allow_in=0, released when ws_allow_in=1.
- Flush in WAIT, new LW enters next cycle, two data_ok pulses with 0xAAAA_AAAA then 0x5555_5555 -> first swallowed, new instruction retires with 0x5555_5555.
- ALU op (req_issued=0) after load back-to-back with ws_allow_in=1 -> one instruction retires per cycle, no bubble after data_ok.
- With MS_ALE_EN, LW at 0x1002 -> ms_ale=1, final_result=0x1002. Without the macro -> ms_ale absent, normal word result.
